// File: rtl/nios2_mul_result_combine_pkg.sv
// rtl/nios2_mul_result_combine_pkg.sv - widths and stage record for the multiply result combiner
package nios2_mul_result_combine_pkg;

  localparam int PART_W = 32;
  localparam int MID_W  = 34;
  localparam int PROD_W = 64;
  localparam int TAG_W  = 5;

  typedef struct packed {
    logic              valid;
    logic [MID_W-1:0]  mid;
    logic [PART_W-1:0] p1;
    logic              p4_ext;
    logic [PART_W-1:0] p4;
    logic              sel_hi;
    logic [TAG_W-1:0]  dst;
  } s1_t;

endpackage

// File: rtl/nios2_mul_ext_add.sv
// rtl/nios2_mul_ext_add.sv - extends the two cross partial products and sums them to 34 bits
module nios2_mul_ext_add
  import nios2_mul_result_combine_pkg::*;
(
  input  logic [PART_W-1:0] p2,
  input  logic [PART_W-1:0] p3,
  input  logic              src1_signed,
  input  logic              src2_signed,
  output logic [MID_W-1:0]  mid
);

  logic [MID_W-1:0] p2_x;
  logic [MID_W-1:0] p3_x;

  // p2 is lo(src1) x hi(src2), so its sign follows src2; p3 is the mirror.
  always_comb begin
    p2_x = {{(MID_W-PART_W){src2_signed & p2[PART_W-1]}}, p2};
    p3_x = {{(MID_W-PART_W){src1_signed & p3[PART_W-1]}}, p3};
    mid  = p2_x + p3_x;
  end

endmodule

// File: rtl/nios2_mul_result_combine.sv
// rtl/nios2_mul_result_combine.sv - two-stage partial-product combiner with ready/valid flow control
module nios2_mul_result_combine
  import nios2_mul_result_combine_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PART_W-1:0] in_p1,
  input  logic [PART_W-1:0] in_p2,
  input  logic [PART_W-1:0] in_p3,
  input  logic [PART_W-1:0] in_p4,
  input  logic              in_src1_signed,
  input  logic              in_src2_signed,
  input  logic              in_sel_hi,
  input  logic [TAG_W-1:0]  in_dst,
  input  logic              in_flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PART_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_dst
);

  s1_t               s1_q, s1_d;
  logic              s2_valid_q, s2_valid_d;
  logic [PART_W-1:0] s2_result_q, s2_result_d;
  logic [TAG_W-1:0]  s2_dst_q, s2_dst_d;

  logic              s2_adv;
  logic              s1_adv;
  logic              accept;
  logic [MID_W-1:0]  mid;
  logic [PROD_W-1:0] mid_term;
  logic [PROD_W-1:0] p4_term;
  logic [PROD_W-1:0] prod;

  nios2_mul_ext_add u_ext_add (
    .p2          (in_p2),
    .p3          (in_p3),
    .src1_signed (in_src1_signed),
    .src2_signed (in_src2_signed),
    .mid         (mid)
  );

  always_comb begin
    s2_adv   = !s2_valid_q | out_ready;
    s1_adv   = s2_adv | !s1_q.valid;
    in_ready = s1_adv & !in_flush & !reset;
    accept   = in_valid & in_ready;

    s1_d = s1_q;
    if (accept) begin
      s1_d.mid    = mid;
      s1_d.p1     = in_p1;
      s1_d.p4_ext = (in_src1_signed | in_src2_signed) & in_p4[PART_W-1];
      s1_d.p4     = in_p4;
      s1_d.sel_hi = in_sel_hi;
      s1_d.dst    = in_dst;
    end
    if (s1_adv) s1_d.valid = accept;
    if (in_flush) s1_d.valid = 1'b0;

    // mid is a signed 34-bit quantity once both extensions are applied.
    mid_term = {{(PROD_W-MID_W){s1_q.mid[MID_W-1]}}, s1_q.mid} << 16;
    p4_term  = {{(PROD_W-PART_W){s1_q.p4_ext}}, s1_q.p4} << 32;
    prod     = {{(PROD_W-PART_W){1'b0}}, s1_q.p1} + mid_term + p4_term;

    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_dst_d    = s2_dst_q;
    if (s2_adv) begin
      s2_valid_d = s1_q.valid;
      if (s1_q.valid) begin
        s2_result_d = s1_q.sel_hi ? prod[PROD_W-1:PART_W] : prod[PART_W-1:0];
        s2_dst_d    = s1_q.dst;
      end
    end
    if (in_flush) s2_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q        <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_dst_q    <= '0;
    end else begin
      s1_q        <= s1_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_dst_q    <= s2_dst_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_result_q;
  assign out_dst    = s2_dst_q;

endmodule

// File: tb/tb_nios2_mul_result_combine.sv
// tb/tb_nios2_mul_result_combine.sv - directed vector bench for the multiply result combiner
module tb_nios2_mul_result_combine;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_p1, in_p2, in_p3, in_p4;
  logic        in_src1_signed, in_src2_signed;
  logic        in_sel_hi;
  logic [4:0]  in_dst;
  logic        in_flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_dst;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] p1, p2, p3, p4;
    logic        s1, s2, sel;
    logic [4:0]  dst;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  nios2_mul_result_combine dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_p1          (in_p1),
    .in_p2          (in_p2),
    .in_p3          (in_p3),
    .in_p4          (in_p4),
    .in_src1_signed (in_src1_signed),
    .in_src2_signed (in_src2_signed),
    .in_sel_hi      (in_sel_hi),
    .in_dst         (in_dst),
    .in_flush       (in_flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_dst        (out_dst)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic valid);
    in_p1 = v.p1; in_p2 = v.p2; in_p3 = v.p3; in_p4 = v.p4;
    in_src1_signed = v.s1; in_src2_signed = v.s2;
    in_sel_hi = v.sel; in_dst = v.dst; in_valid = valid;
  endtask

  function automatic vec_t mk(input logic [31:0] p1, p2, p3, p4, input logic s1, s2, sel,
                              input logic [4:0] dst, input logic [31:0] exp);
    vec_t v;
    v.p1 = p1; v.p2 = p2; v.p3 = p3; v.p4 = p4;
    v.s1 = s1; v.s2 = s2; v.sel = sel; v.dst = dst; v.exp = exp;
    return v;
  endfunction

  task automatic run_vec(input int i, input vec_t v);
    @(negedge clk);
    drive(v, 1'b1);
    out_ready = 1'b1;
    #1 chk($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk($sformatf("vec%0d_early_valid", i), {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'd1);
    chk($sformatf("vec%0d_result", i), out_result, v.exp);
    chk($sformatf("vec%0d_dst", i), {27'b0, out_dst}, {27'b0, v.dst});
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("vec%0d_drain", i), {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    vec_t a, b, c, d;

    vecs[0]  = mk(32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 0, 0, 0, 5'd1,  32'h00000001);
    vecs[1]  = mk(32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 0, 0, 1, 5'd2,  32'hFFFFFFFE);
    vecs[2]  = mk(32'h0001FFFE, 32'h00000000, 32'hFFFFFFFE, 32'h00000000, 1, 1, 0, 5'd3,  32'hFFFFFFFE);
    vecs[3]  = mk(32'h0001FFFE, 32'h00000000, 32'hFFFFFFFE, 32'h00000000, 1, 1, 1, 5'd4,  32'hFFFFFFFF);
    vecs[4]  = mk(32'h00000000, 32'h00000000, 32'h00000000, 32'h40000000, 1, 1, 1, 5'd5,  32'h40000000);
    vecs[5]  = mk(32'h00000000, 32'h00000000, 32'h00000000, 32'h40000000, 1, 1, 0, 5'd6,  32'h00000000);
    vecs[6]  = mk(32'h00000000, 32'h80000000, 32'h00000000, 32'h00000000, 0, 1, 1, 5'd7,  32'hFFFF8000);
    vecs[7]  = mk(32'h00000000, 32'h80000000, 32'h00000000, 32'h00000000, 1, 0, 1, 5'd8,  32'h00008000);
    vecs[8]  = mk(32'h00000000, 32'h00000000, 32'h80000000, 32'h00000000, 1, 0, 1, 5'd9,  32'hFFFF8000);
    vecs[9]  = mk(32'h00000000, 32'h00000000, 32'h80000000, 32'h00000000, 0, 1, 1, 5'd10, 32'h00008000);
    vecs[10] = mk(32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0, 0, 1, 5'd11, 32'h0001FFFF);
    vecs[11] = mk(32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0, 0, 0, 5'd12, 32'hFFFE0000);
    vecs[12] = mk(32'h00020000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0, 0, 0, 5'd13, 32'h00000000);
    vecs[13] = mk(32'h00020000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0, 0, 1, 5'd31, 32'h00020000);

    a = mk(32'h11111111, 0, 0, 0, 0, 0, 0, 5'd5, 32'h11111111);
    b = mk(32'h22222222, 0, 0, 0, 0, 0, 0, 5'd6, 32'h22222222);
    c = mk(32'h33333333, 0, 0, 0, 0, 0, 0, 5'd7, 32'h33333333);
    d = mk(32'h44444444, 0, 0, 0, 0, 0, 0, 5'd9, 32'h44444444);

    reset = 1'b1; in_flush = 1'b0; out_ready = 1'b1;
    drive(a, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", {31'b0, in_ready}, 32'd0);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_out_result", out_result, 32'd0);
    chk("reset_out_dst", {27'b0, out_dst}, 32'd0);
    reset = 1'b0;
    #1 chk("post_reset_in_ready", {31'b0, in_ready}, 32'd1);

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // backpressure: two ops held, third waits, all delivered in order
    @(negedge clk); drive(a, 1'b1); out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk); drive(b, 1'b1);
    @(posedge clk);
    @(negedge clk); drive(c, 1'b1); out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall%0d_in_ready", k), {31'b0, in_ready}, 32'd0);
      chk($sformatf("stall%0d_valid", k), {31'b0, out_valid}, 32'd1);
      chk($sformatf("stall%0d_result", k), out_result, a.exp);
      chk($sformatf("stall%0d_dst", k), {27'b0, out_dst}, {27'b0, a.dst});
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("release_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    chk("bp_second_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_second_result", out_result, b.exp);
    chk("bp_second_dst", {27'b0, out_dst}, {27'b0, b.dst});
    @(posedge clk);
    @(negedge clk);
    chk("bp_third_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_third_result", out_result, c.exp);
    chk("bp_third_dst", {27'b0, out_dst}, {27'b0, c.dst});
    @(posedge clk);
    @(negedge clk);
    chk("bp_empty", {31'b0, out_valid}, 32'd0);

    // flush with both stages full and a new op offered
    drive(a, 1'b1);
    @(posedge clk);
    @(negedge clk); drive(b, 1'b1);
    @(posedge clk);
    @(negedge clk); drive(c, 1'b1); in_flush = 1'b1; out_ready = 1'b0;
    #1 chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk); in_flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush_out_valid0", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("flush_out_valid1", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("flush_out_valid2", {31'b0, out_valid}, 32'd0);
    run_vec(100, d);

    // reset with two ops in flight
    @(negedge clk); drive(a, 1'b1); out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk); drive(b, 1'b1);
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0; reset = 1'b1;
    #1 chk("rst_fly_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_fly_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_fly_out_result", out_result, 32'd0);
    reset = 1'b0;
    #1 chk("rst_fly_in_ready_after", {31'b0, in_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rst_fly_stale%0d", k), {31'b0, out_valid}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
